down_counter_seq: RTL
=====================

# down_counter_seq

Loadable down-counter sequencer with start/done handshake. It is the countdown counterpart to the team's enable-driven up-counter: it loads a programmed count, decrements on each enabled cycle, and signals completion until acknowledged. Loop-control logic in the convolution datapath uses it to bound per-tile iterations, such as kernel rows or output pixels, and gate the next stage.

## Interface
Parameters:
- WIDTH, 4, bit width of load value and count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to load load_val and begin countdown; honoured only in IDLE or DONE.
- load_val  in  WIDTH  initial count, sampled on an accepted start.
- enable  in  1  decrement qualifier; meaningful only in RUN.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- done_ack  in  1  consumer acknowledge of done.
- count_out  out  WIDTH  current remaining count (registered).
- busy  out  1  high while in RUN (registered).
- done  out  1  high while in DONE (registered).
- tick  out  1  one-cycle pulse, high the cycle after each decrement edge.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; outputs are decoded from registers, not from inputs.
- Reset (rst_n=0, asynchronous): state=IDLE, count_out=0, busy=0, done=0, tick=0.
- Per-edge priority: abort > start > done_ack > enable.
- IDLE:
  - start=1 with load_val≠0: count<=load_val, go to RUN.
  - start=1 with load_val=0: count<=0, go straight to DONE with no RUN cycle and no tick.
- RUN:
  - enable=1: count<=count-1 and tick<=1. If count was 1, go to DONE.
  - enable=0: hold count; tick<=0.
  - start is ignored.
- DONE:
  - done stays high until done_ack=1, then go to IDLE. count_out holds 0.
  - start=1 (with or without done_ack): restart exactly as from IDLE; done drops on the same edge.
- abort=1: go to IDLE and set count<=0, tick<=0, from any state, on the same edge.
- Arithmetic: unsigned, modulo 2^WIDTH. Underflow is unreachable because RUN exits at 1→0.
- Enable and done_ack outside their states have no effect.

## Timing
- Start accepted at edge N: count_out=load_val and busy=1 after edge N.
- Latency from start to done = load_val enabled cycles, plus one edge for the load. With load_val=L and enable held high, done rises after edge N+L.
- tick is a registered pulse coincident with the new count_out value. It is never high in two consecutive cycles unless enable was high in consecutive RUN cycles.
- done and busy are mutually exclusive at all times. Both are low in IDLE.
- done_ack at edge M: done=0 and busy=0 after edge M.
- Reset asserted mid-RUN: outputs go to reset values immediately, without waiting for clk.
- Back-to-back runs: start during DONE gives zero idle cycles between runs.

## Test plan
- Reset, then WIDTH=4, start with load_val=5 and enable held 1 → count_out 5,4,3,2,1,0 on successive edges; tick high 5 cycles; done=1 after the 6th edge; busy=0.
- load_val=3, enable toggling 1,0,1,0,1 → count_out 3,2,2,1,1,0; tick only in the decrement cycles; done after the fifth enable-phase edge.
- start with load_val=0 → done=1 one edge later, tick never asserts, busy never asserts.
- In DONE, assert start with load_val=9 and done_ack together → done=0, busy=1, count_out=9 after that edge.
- Mid-RUN (count_out=7 of 15), abort=1 with start=1 → IDLE, count_out=0, busy=0, done=0. Then start with load_val=15 → count_out=15.
- Mid-RUN, drop rst_n between clock edges → all outputs 0 before the next edge. start while busy (load_val=2) → ignored; countdown continues from the current value.

Source files
------------

// File: rtl/down_counter_seq_if.sv
// down_counter_seq_if
//   Handshake/data bundle between a loop controller (master) and the
//   down_counter_seq sequencer (slave).
//   Master drives: start, load_val, enable, abort, done_ack.
//   Slave drives : count_out, busy, done, tick.
interface down_counter_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             abort;
  logic             done_ack;
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             done;
  logic             tick;

  modport master (
    output start, load_val, enable, abort, done_ack,
    input  count_out, busy, done, tick
  );

  modport slave (
    input  start, load_val, enable, abort, done_ack,
    output count_out, busy, done, tick
  );
endinterface

// File: rtl/down_counter_seq.sv
// down_counter_seq
//   Loadable down-counter sequencer. A start in IDLE or DONE loads load_val
//   and counts down on enabled cycles; reaching zero raises done until
//   acknowledged. abort returns to IDLE from anywhere.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of down_counter_seq_if
//            in : start, load_val, enable, abort, done_ack
//            out: count_out, busy, done, tick (all registered)
module down_counter_seq #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  down_counter_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             tick_reg,  tick_next;
  logic             busy_reg,  busy_next;
  logic             done_reg,  done_next;

  // Target of an accepted start: a zero load skips RUN entirely.
  state_t           load_state;
  assign load_state = (bus.load_val == ZERO) ? DONE : RUN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= ZERO;
      tick_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      tick_reg  <= tick_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Priority on each edge: abort > start > done_ack > enable.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    tick_next  = 1'b0;

    if (bus.abort) begin
      state_next = IDLE;
      count_next = ZERO;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_next = load_state;
            count_next = bus.load_val;
          end
        end
        RUN: begin
          // start is deliberately ignored while counting.
          if (bus.enable) begin
            count_next = count_reg - ONE;
            tick_next  = 1'b1;
            if (count_reg == ONE) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          // A start here chains the next run with no idle gap.
          if (bus.start) begin
            state_next = load_state;
            count_next = bus.load_val;
          end else if (bus.done_ack) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = ZERO;
        end
      endcase
    end
  end

  // Status flags are registered copies of the next state so they change
  // on the same edge as the state and never glitch on inputs.
  always_comb begin
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  assign bus.count_out = count_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.tick      = tick_reg;

endmodule
